dword_add_seq: RTL and testbench

DWORD_ADD_SEQ -- requirements
Module: dword_add_seq

---
 rtl/dword_add_seq.sv | 166 ++++++++++++++++
 tb/tb_dword_add_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dword_add_seq.sv
// -----------------------------------------------------------------------------
// dword_add_seq
//   32-bit add/subtract built from a single 16-bit adder slice that is
//   time-shared over two cycles (low half, then high half with the low carry
//   chained in). Subtract is A + ~B + 1. Operands are captured on start, so
//   the inputs may change freely while an operation is in flight.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   request pulse, sampled only in IDLE
//   op        in   0 = add, 1 = subtract (A - B)
//   a_in      in   operand A [31:0]
//   b_in      in   operand B [31:0]
//   flag_clr  in   synchronous clear of Z/N/C/V (result untouched)
//   busy      out  high in LO, HI and DONE
//   done      out  one-cycle completion pulse (DONE state)
//   result    out  last completed result [31:0]
//   z_flag    out  result == 0
//   n_flag    out  result[31]
//   c_flag    out  carry out of bit 31 (for subtract: 1 = no borrow)
//   v_flag    out  signed overflow
// -----------------------------------------------------------------------------
module dword_add_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        flag_clr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        z_flag,
  output logic        n_flag,
  output logic        c_flag,
  output logic        v_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_op;
  logic [15:0] r_lo_sum;
  logic        r_lo_carry;

  logic [31:0] r_result;
  logic        r_z;
  logic        r_n;
  logic        r_c;
  logic        r_v;

  logic [31:0] w_b_eff;       // B' : B inverted for subtract
  logic [15:0] w_slice_a;
  logic [15:0] w_slice_b;
  logic        w_slice_cin;
  logic [16:0] w_slice_sum;
  logic [31:0] w_full_result;

  assign w_b_eff = r_b ^ {32{r_op}};

  // Operand mux for the shared slice: low halves with carry-in = op (the +1
  // of two's-complement subtract), high halves with the stored low carry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    w_slice_a   = r_a[15:0];
    w_slice_b   = w_b_eff[15:0];
    w_slice_cin = r_op;
    if (r_state == S_HI) begin
      w_slice_a   = r_a[31:16];
      w_slice_b   = w_b_eff[31:16];
      w_slice_cin = r_lo_carry;
    end
  end

  assign w_slice_sum   = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {16'd0, w_slice_cin};
  assign w_full_result = {w_slice_sum[15:0], r_lo_sum};

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_LO;
      S_LO:   w_next_state = S_HI;
      S_HI:   w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture and low-slice storage. These are all small registers, so
  // they are reset too, leaving no stale operand visible after an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_lo_sum   <= '0;
      r_lo_carry <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a  <= a_in;
        r_b  <= b_in;
        r_op <= op;
      end
      if (r_state == S_LO) begin
        r_lo_sum   <= w_slice_sum[15:0];
        r_lo_carry <= w_slice_sum[16];
      end
    end
  end

  // Result and flags. The HI->DONE update is checked first so a coincident
  // flag_clr loses to the fresh flags of the completing operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_z      <= 1'b1;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (r_state == S_HI) begin
      r_result <= w_full_result;
      r_z      <= (w_full_result == 32'd0);
      r_n      <= w_slice_sum[15];
      r_c      <= w_slice_sum[16];
      // Overflow: both addends share a sign and the sum's sign differs.
      r_v      <= (r_a[31] == w_b_eff[31]) && (w_slice_sum[15] != r_a[31]);
    end else if (flag_clr) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign z_flag = r_z;
  assign n_flag = r_n;
  assign c_flag = r_c;
  assign v_flag = r_v;

endmodule

// File: tb/tb_dword_add_seq.sv
// -----------------------------------------------------------------------------
// tb_dword_add_seq
//   Self-checking bench: directed corner cases plus randomized operations,
//   compared against a 33-bit arithmetic reference model of add/subtract and
//   the Z/N/C/V flag rules.
// -----------------------------------------------------------------------------
module tb_dword_add_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flag_clr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        z_flag;
  logic        n_flag;
  logic        c_flag;
  logic        v_flag;

  int n_checks;
  int n_errors;

  // Reference state: last completed result and current flags {Z,N,C,V}.
  logic [31:0] exp_result;
  logic [3:0]  exp_flags;

  dword_add_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .flag_clr (flag_clr),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .z_flag   (z_flag),
    .n_flag   (n_flag),
    .c_flag   (c_flag),
    .v_flag   (v_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {z_flag, n_flag, c_flag, v_flag};
  endfunction

  // Reference arithmetic: plain 33-bit add/subtract, flags from the
  // mathematical definitions of carry and signed overflow.
  task automatic model_op(input logic op_i, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] full;
    logic [31:0] r;
    logic        v;
    if (op_i) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else      full = {1'b0, a} + {1'b0, b};
    r = full[31:0];
    if (op_i) v = (a[31] != b[31]) && (r[31] != a[31]);
    else      v = (a[31] == b[31]) && (r[31] != a[31]);
    exp_result = r;
    exp_flags  = {(r == 32'd0), r[31], full[32], v};
  endtask

  task automatic model_reset();
    exp_result = 32'd0;
    exp_flags  = 4'b1000;
  endtask

  // Runs one operation starting right now (called #1 after a rising edge).
  // clr_in_hi raises flag_clr during HI; poke_busy pulses start during LO/HI
  // with other operands, which must be ignored.
  task automatic do_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                       input logic clr_in_hi, input logic poke_busy);
    int cycles;
    op = op_i; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the operation in flight must use captured operands.
    a_in = $urandom; b_in = $urandom; op = 1'($urandom);
    cycles = 1;
    while (!done && cycles < 10) begin
      flag_clr = clr_in_hi && (cycles == 2);
      start    = poke_busy;
      @(posedge clk); #1;
      flag_clr = 1'b0;
      start    = 1'b0;
      cycles++;
    end
    model_op(op_i, a, b);
    check("latency", 32'(cycles), 32'd3);
    check("done_high", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("result", result, exp_result);
    check("flags_zncv", {28'd0, flags_now()}, {28'd0, exp_flags});
    @(posedge clk); #1;
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_watch(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(tag, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] special [6];
    n_checks = 0;
    n_errors = 0;
    special[0] = 32'h0000_0000; special[1] = 32'hFFFF_FFFF;
    special[2] = 32'h7FFF_FFFF; special[3] = 32'h8000_0000;
    special[4] = 32'h0000_FFFF; special[5] = 32'h0000_0001;

    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0; flag_clr = 1'b0;
    model_reset();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, exp_result);
    check("rst_flags", {28'd0, flags_now()}, {28'd0, exp_flags});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First start taken on the first edge after reset release.
    do_op(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("lo_carry_chain", result, 32'h0001_0000);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("wrap_zc", {28'd0, flags_now()}, 32'b1010);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("ovf_nv", {28'd0, flags_now()}, 32'b0101);
    do_op(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    check("sub_borrow", result, 32'hFFFF_FFFF);
    do_op(1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    check("sub_equal_zc", {28'd0, flags_now()}, 32'b1010);

    // start during LO/HI ignored: one done, then quiet.
    do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    idle_watch(4, "no_queued_done");

    // Reset during HI aborts with no done.
    op = 1'b0; a_in = 32'h0000_0003; b_in = 32'h0000_0004; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;   // now in HI
    model_reset();
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_z", {31'd0, z_flag}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    idle_watch(3, "abort_no_done");
    check("abort_hold_result", result, exp_result);

    // flag_clr coinciding with HI->DONE: fresh flags win.
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    check("clr_vs_done", {28'd0, flags_now()}, 32'b1010);
    // flag_clr in IDLE: flags zero, result unchanged.
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    exp_flags = 4'b0000;
    check("idle_clr_flags", {28'd0, flags_now()}, {28'd0, exp_flags});
    check("idle_clr_result", result, exp_result);
    idle_watch(2, "idle_hold");
    check("idle_hold_flags", {28'd0, flags_now()}, {28'd0, exp_flags});

    // Randomized operations, mixing corner operands with random ones.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      do_op(1'($urandom), ra, rb, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) idle_watch(1, "rand_gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
